lsu_queued: RTL and testbench
=============================

Name: lsu_queued

Overview:
- Queued, tag-aware successor of the single-entry load/store execution unit in the execute stage.
- Accepts memory ops from the LSB into an in-order request FIFO of parametrised depth and issues them one at a time to memCtrl.
- Extends loaded data by opcode and broadcasts the result with its ROB tag on the CDB.
- On rollback it squashes speculative loads, both queued and in flight. Committed stores always complete.

Parameters:
- DEPTH, 4: request FIFO entries; power of two, at least 2.
- ADDR_W, 32: address width.
- DATA_W, 32: data width; byte lanes = DATA_W/8.
- TAG_W, 4: ROB tag width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rdy  in  1  global enable; when low, all state and outputs hold
- enable_signal_from_LSB  in  1  request valid
- openum_from_LSB  in  `OPENUM_TYPE  opcode: NOP, LB, LH, LW, LBU, LHU, SB, SH, SW
- address_from_LSB  in  ADDR_W  effective address
- data_from_LSB  in  DATA_W  store data
- tag_from_LSB  in  TAG_W  ROB tag
- ready_signal_to_LSB  out  1  high when the FIFO is not full
- rollback_signal  in  1  squash speculative loads
- finish_flag_from_memctrl  in  1  outstanding access done
- data_from_memctrl  in  DATA_W  read data, little-endian, lane 0 = lowest byte
- enable_signal_to_memctrl  out  1  one-cycle request pulse
- read_or_write_flag_to_memctrl  out  1  `READ_FLAG / `WRITE_FLAG
- size_to_memctrl  out  3  access size in bytes: 1, 2 or 4
- address_to_memctrl  out  ADDR_W  access address
- data_to_memctrl  out  DATA_W  store data; zero for loads
- valid_signal_to_cdb  out  1  one-cycle result pulse
- result_to_cdb  out  DATA_W  extended load data
- tag_to_cdb  out  TAG_W  ROB tag of the result

Behaviour:
- Reset values: all outputs 0; FIFO empty; state IDLE; drop_inflight 0. Reset mid-transaction abandons the in-flight access with no CDB pulse.
- rdy low: no state change; outputs hold their values, so pulses stretch.
- Enqueue:
  - Occurs when enable && ready && opcode != NOP.
  - The entry stores opcode, address, data, tag and killed = 0.
  - NOP is dropped silently.
  - ready_signal_to_LSB = (count != DEPTH) and is registered-count based. No enqueue happens when full, even if a pop occurs in the same cycle.
- Pointers: wrap modulo DEPTH. count saturates only via the ready gating.
- States: IDLE, WAIT.
- IDLE, FIFO empty: enable_signal_to_memctrl = 0.
- IDLE, head killed: pop the head without a memory access and stay in IDLE. This costs one cycle per killed entry.
- IDLE, head live:
  - At the next edge, drive enable = 1, size, address, flag and data from the head.
  - Pop the head, latch opcode and tag into in-flight registers, and go to WAIT.
- WAIT: enable is forced to 0 after its single cycle. Ignore memctrl data until finish.
- WAIT, finish high:
  - Go to IDLE.
  - If the in-flight op is a load and drop_inflight == 0, then in the next cycle valid_signal_to_cdb = 1, result_to_cdb = extended data and tag_to_cdb = the latched tag.
  - Stores produce no CDB pulse.
  - drop_inflight clears to 0.
- valid_signal_to_cdb is 1 for exactly one rdy-high cycle.
- Issue timing: a new request may issue the cycle after the return to IDLE, at the earliest. This gives back-to-back throughput of one access per (memory latency + 2) cycles.
- Extension rules:
  - LB: sign-extend bits [7:0].
  - LH: sign-extend bits [15:0].
  - LW: all DATA_W bits.
  - LBU: zero-extend bits [7:0].
  - LHU: zero-extend bits [15:0].
  - Sizes: SB = 1, SH = 2, SW = 4.
- Rollback (single cycle):
  - Every queued load gets killed = 1; queued stores are untouched.
  - If in WAIT on a load, set drop_inflight = 1. The memory access still finishes, and its result is discarded.
  - A load presented in the same cycle as rollback is not enqueued. A store presented in that cycle is enqueued normally.
- Ordering: strict FIFO order. A store issued earlier completes before any later load issues.
- Misalignment: not checked; address is passed through unchanged and memCtrl owns alignment.

Decomposition:
- Shared constant package (existing constant header): `OPENUM_* codes, `READ_FLAG / `WRITE_FLAG, `TRUE / `FALSE, `ZERO_WORD, and a new size-code constant set: SIZE_B = 1, SIZE_H = 2, SIZE_W = 4.
- One sub-module, lsu_req_fifo: the parametrised circular buffer with per-entry killed bit, a mass-kill-loads input, a push/pop interface, and head/full/empty outputs.
- Sequencing and extension logic stay in lsu_queued.

Test Plan:
- LB to 0x100, memctrl returns 0x000000F0 after 3 cycles:
  - enable pulses once with size 1 and READ;
  - CDB pulses once with 0xFFFFFFF0 and the matching tag, one cycle after finish.
- LBU, LHU and LH with data 0x0000_8081:
  - results 0x00000081, 0x00008081 and 0xFFFF8081 respectively.
- SW of 0xDEADBEEF to 0x200, then LW to 0x200:
  - write issues first with size 4 and data 0xDEADBEEF, with no CDB pulse;
  - load issues only after the write's finish.
- Push DEPTH+1 ops with memctrl stalled:
  - ready drops after DEPTH pushes and the extra request is not accepted;
  - ready rises the cycle after the first pop.
- Queue [LW A, SB B, LW C] with LW A in flight, then rollback:
  - LW A's finish yields no CDB pulse;
  - C is popped without an enable;
  - SB B still issues.
- Hold rdy low during WAIT with finish high:
  - no state change while rdy is low;
  - on rdy high, exactly one CDB pulse.
- Assert rst while in WAIT:
  - all outputs go to 0;
  - a later finish produces no pulse.

Source files
------------

// File: rtl/lsu_queued_pkg.sv
// lsu_queued_pkg: shared constants for the queued load/store unit.
//   - opcode codes (OPENUM_*) and the openum_t type
//   - memCtrl direction flags (READ_FLAG / WRITE_FLAG), TRUE / FALSE, ZERO_WORD
//   - access-size codes in bytes (SIZE_B / SIZE_H / SIZE_W)
//   - sequencer state type and small opcode helpers
package lsu_queued_pkg;

    localparam int OPENUM_W = 4;
    typedef logic [OPENUM_W-1:0] openum_t;

    localparam openum_t OPENUM_NOP = 4'd0;
    localparam openum_t OPENUM_LB  = 4'd1;
    localparam openum_t OPENUM_LH  = 4'd2;
    localparam openum_t OPENUM_LW  = 4'd3;
    localparam openum_t OPENUM_LBU = 4'd4;
    localparam openum_t OPENUM_LHU = 4'd5;
    localparam openum_t OPENUM_SB  = 4'd6;
    localparam openum_t OPENUM_SH  = 4'd7;
    localparam openum_t OPENUM_SW  = 4'd8;

    localparam logic READ_FLAG  = 1'b0;
    localparam logic WRITE_FLAG = 1'b1;
    localparam logic TRUE       = 1'b1;
    localparam logic FALSE      = 1'b0;

    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    localparam logic [2:0] SIZE_B = 3'd1;
    localparam logic [2:0] SIZE_H = 3'd2;
    localparam logic [2:0] SIZE_W = 3'd4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    function automatic logic is_load(input openum_t op);
        return (op == OPENUM_LB) || (op == OPENUM_LH) || (op == OPENUM_LW) ||
               (op == OPENUM_LBU) || (op == OPENUM_LHU);
    endfunction

    function automatic logic [2:0] op_size(input openum_t op);
        logic [2:0] sz;
        sz = SIZE_W;
        case (op)
            OPENUM_LB, OPENUM_LBU, OPENUM_SB: sz = SIZE_B;
            OPENUM_LH, OPENUM_LHU, OPENUM_SH: sz = SIZE_H;
            default:                          sz = SIZE_W;
        endcase
        return sz;
    endfunction

endpackage

// File: rtl/lsu_queued_fifo.sv
// lsu_req_fifo: in-order circular request buffer with a per-entry killed bit.
//   clk_i, rst_i        clock, synchronous active-high reset
//   en_i                global enable; when low nothing changes
//   push_i, push_*_i    enqueue one entry (ignored when full); killed starts at 0
//   pop_i               drop the head entry (ignored when empty)
//   kill_loads_i        mark every queued load as killed
//   head_*_o            fields of the head entry (meaningful when !empty_o)
//   empty_o             no entries
//   full_next_o         count will equal DEPTH after the coming edge
module lsu_req_fifo
    import lsu_queued_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int TAG_W  = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic              push_i,
    input  openum_t           push_op_i,
    input  logic [ADDR_W-1:0] push_addr_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic [TAG_W-1:0]  push_tag_i,
    input  logic              pop_i,
    input  logic              kill_loads_i,
    output openum_t           head_op_o,
    output logic [ADDR_W-1:0] head_addr_o,
    output logic [DATA_W-1:0] head_data_o,
    output logic [TAG_W-1:0]  head_tag_o,
    output logic              head_killed_o,
    output logic              empty_o,
    output logic              full_next_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    openum_t           op_q   [DEPTH];
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [TAG_W-1:0]  tag_q  [DEPTH];
    logic [DEPTH-1:0]  killed_q;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        do_push  = push_i && (count_q != CNT_W'(DEPTH));
        do_pop   = pop_i && (count_q != '0);
        // Pointers are PTR_W bits wide, so they wrap modulo DEPTH for free.
        wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
        rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
        count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            killed_q <= '0;
        end else if (en_i) begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (kill_loads_i) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (is_load(op_q[i])) killed_q[i] <= 1'b1;
                end
            end
            // Written after the kill loop so a fresh entry always starts live.
            if (do_push) begin
                op_q[wr_ptr_q]     <= push_op_i;
                addr_q[wr_ptr_q]   <= push_addr_i;
                data_q[wr_ptr_q]   <= push_data_i;
                tag_q[wr_ptr_q]    <= push_tag_i;
                killed_q[wr_ptr_q] <= 1'b0;
            end
        end
    end

    assign head_op_o     = op_q[rd_ptr_q];
    assign head_addr_o   = addr_q[rd_ptr_q];
    assign head_data_o   = data_q[rd_ptr_q];
    assign head_tag_o    = tag_q[rd_ptr_q];
    assign head_killed_o = killed_q[rd_ptr_q];
    assign empty_o       = (count_q == '0);
    assign full_next_o   = (count_d == CNT_W'(DEPTH));

endmodule

// File: rtl/lsu_queued.sv
// lsu_queued: queued, tag-aware load/store unit.
//   LSB side:     enable/openum/address/data/tag_from_LSB in, ready_signal_to_LSB out
//   rollback:     rollback_signal squashes speculative loads (queued and in flight)
//   memCtrl side: finish_flag/data_from_memctrl in; enable, read_or_write_flag,
//                 size, address, data_to_memctrl out (enable is a one-cycle pulse)
//   CDB side:     valid_signal_to_cdb (one-cycle pulse), result_to_cdb, tag_to_cdb
// rdy low freezes every register, so output pulses stretch over the stall.
module lsu_queued
    import lsu_queued_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int TAG_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              enable_signal_from_LSB,
    input  openum_t           openum_from_LSB,
    input  logic [ADDR_W-1:0] address_from_LSB,
    input  logic [DATA_W-1:0] data_from_LSB,
    input  logic [TAG_W-1:0]  tag_from_LSB,
    output logic              ready_signal_to_LSB,
    input  logic              rollback_signal,
    input  logic              finish_flag_from_memctrl,
    input  logic [DATA_W-1:0] data_from_memctrl,
    output logic              enable_signal_to_memctrl,
    output logic              read_or_write_flag_to_memctrl,
    output logic [2:0]        size_to_memctrl,
    output logic [ADDR_W-1:0] address_to_memctrl,
    output logic [DATA_W-1:0] data_to_memctrl,
    output logic              valid_signal_to_cdb,
    output logic [DATA_W-1:0] result_to_cdb,
    output logic [TAG_W-1:0]  tag_to_cdb
);
    state_e            state_q, state_d;
    openum_t           fl_op_q, fl_op_d;
    logic [TAG_W-1:0]  fl_tag_q, fl_tag_d;
    logic              drop_q, drop_d;
    logic              ready_q, ready_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [2:0]        mem_size_q, mem_size_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_data_q, mem_data_d;
    logic              cdb_valid_q, cdb_valid_d;
    logic [DATA_W-1:0] cdb_res_q, cdb_res_d;
    logic [TAG_W-1:0]  cdb_tag_q, cdb_tag_d;

    openum_t           head_op;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;
    logic [TAG_W-1:0]  head_tag;
    logic              head_killed, fifo_empty, full_next;
    logic              push, pop;

    function automatic logic [DATA_W-1:0] extend(input openum_t op, input logic [DATA_W-1:0] d);
        logic [DATA_W-1:0] r;
        r = d;
        case (op)
            OPENUM_LB:  r = {{(DATA_W-8){d[7]}}, d[7:0]};
            OPENUM_LH:  r = {{(DATA_W-16){d[15]}}, d[15:0]};
            OPENUM_LBU: r = {{(DATA_W-8){1'b0}}, d[7:0]};
            OPENUM_LHU: r = {{(DATA_W-16){1'b0}}, d[15:0]};
            default:    r = d;
        endcase
        return r;
    endfunction

    // A load arriving together with rollback is already speculative-dead.
    assign push = enable_signal_from_LSB && ready_q && (openum_from_LSB != OPENUM_NOP) &&
                  !(rollback_signal && is_load(openum_from_LSB));

    lsu_req_fifo #(
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .TAG_W (TAG_W)
    ) u_fifo (
        .clk_i        (clk),
        .rst_i        (rst),
        .en_i         (rdy),
        .push_i       (push),
        .push_op_i    (openum_from_LSB),
        .push_addr_i  (address_from_LSB),
        .push_data_i  (data_from_LSB),
        .push_tag_i   (tag_from_LSB),
        .pop_i        (pop),
        .kill_loads_i (rollback_signal),
        .head_op_o    (head_op),
        .head_addr_o  (head_addr),
        .head_data_o  (head_data),
        .head_tag_o   (head_tag),
        .head_killed_o(head_killed),
        .empty_o      (fifo_empty),
        .full_next_o  (full_next)
    );

    always_comb begin
        state_d     = state_q;
        fl_op_d     = fl_op_q;
        fl_tag_d    = fl_tag_q;
        drop_d      = drop_q;
        mem_en_d    = FALSE;
        mem_we_d    = mem_we_q;
        mem_size_d  = mem_size_q;
        mem_addr_d  = mem_addr_q;
        mem_data_d  = mem_data_q;
        cdb_valid_d = FALSE;
        cdb_res_d   = cdb_res_q;
        cdb_tag_d   = cdb_tag_q;
        pop         = 1'b0;
        // Registered from the next count, so ready reads 0 during reset.
        ready_d     = !full_next;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop = 1'b1;
                    // A head load hit by this cycle's rollback is treated as killed.
                    if (!head_killed && !(rollback_signal && is_load(head_op))) begin
                        mem_en_d   = TRUE;
                        mem_we_d   = is_load(head_op) ? READ_FLAG : WRITE_FLAG;
                        mem_size_d = op_size(head_op);
                        mem_addr_d = head_addr;
                        mem_data_d = is_load(head_op) ? DATA_W'(ZERO_WORD) : head_data;
                        fl_op_d    = head_op;
                        fl_tag_d   = head_tag;
                        state_d    = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (finish_flag_from_memctrl) begin
                    state_d = ST_IDLE;
                    drop_d  = FALSE;
                    if (is_load(fl_op_q) && !drop_q && !rollback_signal) begin
                        cdb_valid_d = TRUE;
                        cdb_res_d   = extend(fl_op_q, data_from_memctrl);
                        cdb_tag_d   = fl_tag_q;
                    end
                end else if (rollback_signal && is_load(fl_op_q)) begin
                    drop_d = TRUE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            fl_op_q     <= OPENUM_NOP;
            fl_tag_q    <= '0;
            drop_q      <= FALSE;
            ready_q     <= FALSE;
            mem_en_q    <= FALSE;
            mem_we_q    <= 1'b0;
            mem_size_q  <= '0;
            mem_addr_q  <= '0;
            mem_data_q  <= '0;
            cdb_valid_q <= FALSE;
            cdb_res_q   <= '0;
            cdb_tag_q   <= '0;
        end else if (rdy) begin
            state_q     <= state_d;
            fl_op_q     <= fl_op_d;
            fl_tag_q    <= fl_tag_d;
            drop_q      <= drop_d;
            ready_q     <= ready_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_size_q  <= mem_size_d;
            mem_addr_q  <= mem_addr_d;
            mem_data_q  <= mem_data_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_res_q   <= cdb_res_d;
            cdb_tag_q   <= cdb_tag_d;
        end
    end

    assign ready_signal_to_LSB           = ready_q;
    assign enable_signal_to_memctrl      = mem_en_q;
    assign read_or_write_flag_to_memctrl = mem_we_q;
    assign size_to_memctrl               = mem_size_q;
    assign address_to_memctrl            = mem_addr_q;
    assign data_to_memctrl               = mem_data_q;
    assign valid_signal_to_cdb           = cdb_valid_q;
    assign result_to_cdb                 = cdb_res_q;
    assign tag_to_cdb                    = cdb_tag_q;

endmodule

// File: tb/tb_lsu_queued.sv
// tb_lsu_queued: directed-vector bench for lsu_queued.
module tb_lsu_queued;
    import lsu_queued_pkg::*;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int TAG_W  = 4;

    logic              clk = 1'b0;
    logic              rst, rdy;
    logic              en_lsb;
    openum_t           op_lsb;
    logic [ADDR_W-1:0] addr_lsb;
    logic [DATA_W-1:0] data_lsb;
    logic [TAG_W-1:0]  tag_lsb;
    logic              ready_lsb;
    logic              rollback;
    logic              mem_fin;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_en, mem_we;
    logic [2:0]        mem_size;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              cdb_valid;
    logic [DATA_W-1:0] cdb_res;
    logic [TAG_W-1:0]  cdb_tag;

    int n_vec  = 0;
    int n_miss = 0;

    lsu_queued #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
        .clk                          (clk),
        .rst                          (rst),
        .rdy                          (rdy),
        .enable_signal_from_LSB       (en_lsb),
        .openum_from_LSB              (op_lsb),
        .address_from_LSB             (addr_lsb),
        .data_from_LSB                (data_lsb),
        .tag_from_LSB                 (tag_lsb),
        .ready_signal_to_LSB          (ready_lsb),
        .rollback_signal              (rollback),
        .finish_flag_from_memctrl     (mem_fin),
        .data_from_memctrl            (mem_rdata),
        .enable_signal_to_memctrl     (mem_en),
        .read_or_write_flag_to_memctrl(mem_we),
        .size_to_memctrl              (mem_size),
        .address_to_memctrl           (mem_addr),
        .data_to_memctrl              (mem_wdata),
        .valid_signal_to_cdb          (cdb_valid),
        .result_to_cdb                (cdb_res),
        .tag_to_cdb                   (cdb_tag)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- drivers ----------------
    // All driving and sampling happens 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input openum_t op, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d, input logic [TAG_W-1:0] t);
        en_lsb   = 1'b1;
        op_lsb   = op;
        addr_lsb = a;
        data_lsb = d;
        tag_lsb  = t;
        tick();
        en_lsb   = 1'b0;
        op_lsb   = OPENUM_NOP;
    endtask

    task automatic wait_issue(input string tag, input int max_cycles);
        int n = 0;
        while (!mem_en && n < max_cycles) begin
            tick();
            n++;
        end
        check({tag, "_issue"}, mem_en, 1);
    endtask

    task automatic quiet(input string tag, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            check({tag, "_en_low"}, mem_en, 0);
            check({tag, "_cdb_low"}, cdb_valid, 0);
            tick();
        end
    endtask

    task automatic finish_mem(input logic [DATA_W-1:0] d);
        mem_fin   = 1'b1;
        mem_rdata = d;
        tick();
        mem_fin   = 1'b0;
        mem_rdata = 32'hA5A5_A5A5;
    endtask

    task automatic check_cdb(input string tag, input logic [DATA_W-1:0] res,
                             input logic [TAG_W-1:0] t);
        check({tag, "_cdb_valid"}, cdb_valid, 1);
        check({tag, "_cdb_result"}, cdb_res, res);
        check({tag, "_cdb_tag"}, cdb_tag, t);
        tick();
        check({tag, "_cdb_single"}, cdb_valid, 0);
    endtask

    task automatic do_load(input string tag, input openum_t op, input logic [ADDR_W-1:0] a,
                           input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] mdata,
                           input logic [DATA_W-1:0] exp_res, input logic [2:0] exp_size);
        present(op, a, 32'h5555_5555, t);
        wait_issue(tag, 10);
        check({tag, "_flag"}, mem_we, READ_FLAG);
        check({tag, "_size"}, mem_size, exp_size);
        check({tag, "_addr"}, mem_addr, a);
        check({tag, "_wdata"}, mem_wdata, 0);
        tick();
        quiet(tag, 2);
        finish_mem(mdata);
        check_cdb(tag, exp_res, t);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1; rdy = 1'b1; en_lsb = 1'b0; op_lsb = OPENUM_NOP;
        addr_lsb = '0; data_lsb = '0; tag_lsb = '0; rollback = 1'b0;
        mem_fin = 1'b0; mem_rdata = '0;
        tick();
        tick();
        check("rst_en", mem_en, 0);
        check("rst_size", mem_size, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_cdb_valid", cdb_valid, 0);
        check("rst_ready", ready_lsb, 0);
        rst = 1'b0;
        tick();
        check("post_rst_ready", ready_lsb, 1);

        // Signed / unsigned extension.
        do_load("lb",  OPENUM_LB,  32'h100, 4'h3, 32'h0000_00F0, 32'hFFFF_FFF0, SIZE_B);
        do_load("lbu", OPENUM_LBU, 32'h104, 4'h4, 32'h0000_8081, 32'h0000_0081, SIZE_B);
        do_load("lhu", OPENUM_LHU, 32'h108, 4'h5, 32'h0000_8081, 32'h0000_8081, SIZE_H);
        do_load("lh",  OPENUM_LH,  32'h10C, 4'h6, 32'h0000_8081, 32'hFFFF_8081, SIZE_H);

        // NOP is dropped silently.
        present(OPENUM_NOP, 32'h1F0, 32'h0, 4'h1);
        quiet("nop", 3);

        // Store then load: the load waits for the store's finish.
        present(OPENUM_SW, 32'h200, 32'hDEAD_BEEF, 4'h5);
        present(OPENUM_LW, 32'h200, 32'h0, 4'h6);
        wait_issue("sw", 10);
        check("sw_flag", mem_we, WRITE_FLAG);
        check("sw_size", mem_size, SIZE_W);
        check("sw_addr", mem_addr, 32'h200);
        check("sw_wdata", mem_wdata, 32'hDEAD_BEEF);
        tick();
        quiet("sw_hold", 4);
        finish_mem(32'h0);
        check("sw_no_cdb", cdb_valid, 0);
        wait_issue("lw", 10);
        check("lw_flag", mem_we, READ_FLAG);
        check("lw_addr", mem_addr, 32'h200);
        check("lw_size", mem_size, SIZE_W);
        tick();
        finish_mem(32'hDEAD_BEEF);
        check_cdb("lw", 32'hDEAD_BEEF, 4'h6);

        // Fill with memctrl stalled on an in-flight store.
        present(OPENUM_SW, 32'h300, 32'h0, 4'h0);
        wait_issue("fill_head", 10);
        tick();
        for (int i = 0; i < DEPTH; i++) begin
            check("fill_ready", ready_lsb, 1);
            present(OPENUM_SB, 32'h400 + i, i, TAG_W'(i + 1));
        end
        check("full_ready", ready_lsb, 0);
        en_lsb = 1'b1; op_lsb = OPENUM_SB; addr_lsb = 32'hBAD0; data_lsb = 32'hBAD;
        tick();
        check("full_ready_hold", ready_lsb, 0);
        tick();
        en_lsb = 1'b0; op_lsb = OPENUM_NOP;
        finish_mem(32'h0);
        check("rdy_before_pop", ready_lsb, 0);
        tick();
        check("rdy_after_pop", ready_lsb, 1);
        for (int i = 0; i < DEPTH; i++) begin
            wait_issue("drain", 10);
            check("drain_addr", mem_addr, 32'h400 + i);
            check("drain_wdata", mem_wdata, i);
            check("drain_size", mem_size, SIZE_B);
            tick();
            finish_mem(32'h0);
        end
        quiet("no_extra", 4);

        // Rollback: in-flight load dropped, queued load killed, store survives.
        present(OPENUM_LW, 32'h500, 32'h0, 4'h7);
        wait_issue("rb_a", 10);
        tick();
        present(OPENUM_SB, 32'h504, 32'hAB, 4'h8);
        present(OPENUM_LW, 32'h508, 32'h0, 4'h9);
        rollback = 1'b1;
        present(OPENUM_LW, 32'h50C, 32'h0, 4'hA);
        rollback = 1'b0;
        quiet("rb_wait", 1);
        finish_mem(32'h1111_1111);
        check("rb_a_dropped", cdb_valid, 0);
        wait_issue("rb_b", 10);
        check("rb_b_addr", mem_addr, 32'h504);
        check("rb_b_flag", mem_we, WRITE_FLAG);
        check("rb_b_wdata", mem_wdata, 32'hAB);
        tick();
        finish_mem(32'h0);
        quiet("rb_c_killed", 4);
        do_load("post_rb", OPENUM_LW, 32'h600, 4'hB, 32'hCAFE_F00D, 32'hCAFE_F00D, SIZE_W);

        // rdy low during WAIT with finish high.
        present(OPENUM_LW, 32'h700, 32'h0, 4'hC);
        wait_issue("stall", 10);
        tick();
        rdy = 1'b0; mem_fin = 1'b1; mem_rdata = 32'h1234_5678;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_cdb_low", cdb_valid, 0);
        end
        rdy = 1'b1;
        tick();
        check("stall_cdb_valid", cdb_valid, 1);
        check("stall_cdb_result", cdb_res, 32'h1234_5678);
        check("stall_cdb_tag", cdb_tag, 4'hC);
        mem_fin = 1'b0; rdy = 1'b0;
        tick();
        check("stall_cdb_stretch", cdb_valid, 1);
        rdy = 1'b1;
        tick();
        check("stall_cdb_single", cdb_valid, 0);

        // Reset while a load is in flight.
        present(OPENUM_LW, 32'h800, 32'h0, 4'hD);
        wait_issue("rst_wait", 10);
        rst = 1'b1;
        tick();
        check("rstw_en", mem_en, 0);
        check("rstw_flag", mem_we, 0);
        check("rstw_size", mem_size, 0);
        check("rstw_addr", mem_addr, 0);
        check("rstw_wdata", mem_wdata, 0);
        check("rstw_cdb_valid", cdb_valid, 0);
        check("rstw_cdb_result", cdb_res, 0);
        check("rstw_cdb_tag", cdb_tag, 0);
        check("rstw_ready", ready_lsb, 0);
        rst = 1'b0;
        tick();
        finish_mem(32'h0000_FFFF);
        quiet("rstw_no_pulse", 3);
        check("rstw_ready_back", ready_lsb, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
